// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand transmitter for the GEMM systolic array. Accepts one N-lane A vector
//   and one N-lane B vector per beat, applies diagonal skew (lane i delayed by
//   i advance steps), raises start_compute alongside the edge data, flushes
//   zero vectors until every PE has seen its last operand, then pulses done.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start, k_len        begin a feed of k_len beats (k_len sampled on accept)
//   in_valid, in_ready  beat handshake; in_ready is high only while streaming
//   a_vec, b_vec        N lanes of DATA_WIDTH, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   a_edge, b_edge      skewed, registered operands to the array's left/top edges
//   start_compute       registered array enable, aligned with a_edge/b_edge
//   busy                high while streaming or flushing
//   done                one-cycle pulse once the array result is complete
//   stall_count         (FEED_PERF_EN only) streaming cycles with in_valid low,
//                       saturating, cleared on reset and on start acceptance
//
// Build option: define FEED_PERF_EN to add the stall_count output and counter.

module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] a_vec,
    input  logic [N*DATA_WIDTH-1:0] b_vec,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge,
    output logic                    start_compute,
    output logic                    busy,
    output logic                    done
`ifdef FEED_PERF_EN
    ,
    output logic [15:0]             stall_count
`endif
);

    localparam int DW        = DATA_WIDTH;
    localparam int FLUSH_LEN = 2 * N - 2;
    localparam int FW        = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_q;
    logic [K_W-1:0] beat_cnt;
    logic [FW-1:0]  fl_cnt;
    logic           accept;
    logic           adv;
    logic           load;
    logic           inject;

    assign in_ready = (state_q == STREAM);
    assign busy     = (state_q == STREAM) || (state_q == FLUSH);
    assign accept   = in_valid && in_ready;
    assign adv      = accept || (state_q == FLUSH);
    assign load     = (state_q == IDLE) && start && (k_len != '0);
    assign inject   = (state_q == STREAM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (k_len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (accept && (beat_cnt == k_q - 1'b1)) begin
                    state_d = (N == 1) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (fl_cnt == FW'(FLUSH_LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q           <= '0;
            beat_cnt      <= '0;
            fl_cnt        <= '0;
            start_compute <= 1'b0;
            done          <= 1'b0;
        end else begin
            start_compute <= adv;
            done          <= (state_q == DONE);
            if (load) begin
                k_q      <= k_len;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state_q == FLUSH) begin
                fl_cnt <= fl_cnt + 1'b1;
            end else begin
                fl_cnt <= '0;
            end
        end
    end

    // Lane i is a depth-i packed shift line feeding its edge register; the
    // oldest entry sits in the top DW bits. Everything moves only on adv, so
    // an input stall freezes the whole diagonal together with the PE grid.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_in, b_in, a_q, b_q;

        assign a_in = inject ? a_vec[i*DW +: DW] : '0;
        assign b_in = inject ? b_vec[i*DW +: DW] : '0;

        if (i == 0) begin : g_direct
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end else begin : g_delay
            logic [i*DW-1:0] a_dly, b_dly;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_dly <= '0;
                    b_dly <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (load) begin
                    a_dly <= '0;
                    b_dly <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (adv) begin
                    a_dly <= (i*DW)'({a_dly, a_in});
                    b_dly <= (i*DW)'({b_dly, b_in});
                    a_q   <= a_dly[i*DW-1 -: DW];
                    b_q   <= b_dly[i*DW-1 -: DW];
                end
            end
        end

        assign a_edge[i*DW +: DW] = a_q;
        assign b_edge[i*DW +: DW] = b_q;
    end

`ifdef FEED_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_count <= '0;
        end else if ((state_q == STREAM) && !in_valid && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: one N=4 instance and one N=1
// instance, randomized data/valid patterns, expectations from a list-based
// model of the feed timeline (beats, zero flush, diagonal lane delays).

module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int KW = 8;
    localparam int H  = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n, start, start1, in_valid;
    logic [KW-1:0]   k_len;
    logic [N*DW-1:0] a_vec, b_vec, a_edge, b_edge;
    logic            in_ready, start_compute, busy, done;
    logic [DW-1:0]   a_vec1, b_vec1, a_edge1, b_edge1;
    logic            in_ready1, start_compute1, busy1, done1;
`ifdef FEED_PERF_EN
    logic [15:0]     stall_count, stall_count1;
`endif

    systolic_feeder #(.DATA_WIDTH(DW), .N(N), .K_W(KW)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .a_edge(a_edge), .b_edge(b_edge), .start_compute(start_compute),
        .busy(busy), .done(done)
`ifdef FEED_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    systolic_feeder #(.DATA_WIDTH(DW), .N(1), .K_W(KW)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready1), .a_vec(a_vec1), .b_vec(b_vec1),
        .a_edge(a_edge1), .b_edge(b_edge1), .start_compute(start_compute1),
        .busy(busy1), .done(done1)
`ifdef FEED_PERF_EN
        , .stall_count(stall_count1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hz;

    // stimulus plan
    bit              vpat   [H];
    logic [N*DW-1:0] beat_a [16];
    logic [N*DW-1:0] beat_b [16];

    // model expectations
    bit              e_ready [H], e_busy [H], e_sc [H], e_done [H];
    int              e_beat  [H];
    logic [N*DW-1:0] e_a [H], e_b [H];
    int              e_stall, e_done_cyc;

    // observations
    logic            o_sc [H], o_done [H], o_busy [H], o_ready [H];
    logic [N*DW-1:0] o_a [H], o_b [H];
    logic            o1_sc [H], o1_done [H], o1_busy [H], o1_ready [H];
    logic [DW-1:0]   o1_a [H], o1_b [H];
    logic [15:0]     o_stall, o1_stall;

    // Feed timeline: start accepted at cycle 0, streaming from cycle 1 until K
    // beats are taken (one per valid cycle), then 2n-2 zero vectors, done one
    // cycle after the last feed step's successor. After the s-th advance, lane
    // i of the edge shows the (s-i)-th injected vector, on the next cycle.
    function automatic void build_model(input int n, input int K);
        logic [N*DW-1:0] inj_a [$];
        logic [N*DW-1:0] inj_b [$];
        logic [N*DW-1:0] cur_a, cur_b, ta, tb;
        bit              advc [H];
        int              c, acc, s, idx;
        for (int j = 0; j < H; j++) begin
            e_ready[j] = 0; e_busy[j] = 0; e_sc[j] = 0; e_done[j] = 0;
            e_beat[j] = 0; advc[j] = 0;
        end
        e_stall = 0;
        if (K == 0) begin
            e_done_cyc = 2;
        end else begin
            c = 1; acc = 0;
            while (acc < K && c < H) begin
                e_ready[c] = 1; e_busy[c] = 1; e_beat[c] = acc;
                if (vpat[c]) begin
                    advc[c] = 1;
                    inj_a.push_back(beat_a[acc]);
                    inj_b.push_back(beat_b[acc]);
                    acc++;
                end else begin
                    e_stall++;
                end
                c++;
            end
            for (int f = 0; f < 2 * n - 2; f++) begin
                e_busy[c] = 1; advc[c] = 1;
                inj_a.push_back('0);
                inj_b.push_back('0);
                c++;
            end
            e_done_cyc = c + 1;
        end
        if (e_done_cyc < H) e_done[e_done_cyc] = 1;
        cur_a = '0; cur_b = '0; s = 0;
        e_a[0] = '0; e_b[0] = '0;
        for (int j = 1; j < H; j++) begin
            e_a[j] = cur_a; e_b[j] = cur_b;
            if (advc[j]) begin
                s++;
                for (int i = 0; i < n; i++) begin
                    idx = s - 1 - i;
                    if (idx >= 0) begin
                        ta = inj_a[idx]; tb = inj_b[idx];
                        cur_a[i*DW +: DW] = ta[i*DW +: DW];
                        cur_b[i*DW +: DW] = tb[i*DW +: DW];
                    end else begin
                        cur_a[i*DW +: DW] = '0;
                        cur_b[i*DW +: DW] = '0;
                    end
                end
                if (j + 1 < H) e_sc[j + 1] = 1;
            end
        end
    endfunction

    // Drives one feed and records both instances' outputs mid-cycle.
    task automatic run_feed(input bit n1_mode, input int K, input int horizon, input int restart_cyc);
        for (int c = 0; c < horizon; c++) begin
            @(posedge clk); #1;
            start  = !n1_mode && (c == 0 || c == restart_cyc);
            start1 = n1_mode && (c == 0);
            if (c == restart_cyc) k_len = KW'(5);
            else if (c == 0)      k_len = KW'(K);
            else                  k_len = KW'($urandom);
            in_valid = vpat[c];
            if (vpat[c] && e_ready[c]) begin
                a_vec = beat_a[e_beat[c]];
                b_vec = beat_b[e_beat[c]];
            end else begin
                a_vec = (N*DW)'($urandom);
                b_vec = (N*DW)'($urandom);
            end
            a_vec1 = a_vec[DW-1:0];
            b_vec1 = b_vec[DW-1:0];
            #4;
            o_sc[c] = start_compute; o_done[c] = done; o_busy[c] = busy; o_ready[c] = in_ready;
            o_a[c] = a_edge; o_b[c] = b_edge;
            o1_sc[c] = start_compute1; o1_done[c] = done1; o1_busy[c] = busy1; o1_ready[c] = in_ready1;
            o1_a[c] = a_edge1; o1_b[c] = b_edge1;
        end
`ifdef FEED_PERF_EN
        o_stall  = stall_count;
        o1_stall = stall_count1;
`else
        o_stall  = '0;
        o1_stall = '0;
`endif
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic set_seq_beats();
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < N; i++) beat_a[b][i*DW +: DW] = DW'(4 * b + i + 1);
            beat_b[b] = (N*DW)'($urandom);
        end
    endtask

    task automatic set_vpat_all();
        for (int c = 0; c < H; c++) vpat[c] = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; start1 = 0; in_valid = 0; k_len = '0;
        a_vec = '0; b_vec = '0; a_vec1 = '0; b_vec1 = '0;
        #1;
        n_checks++;
        if ({a_edge, b_edge} !== '0) $display("FAIL reset_edges got=%h exp=0", {a_edge, b_edge}); else n_pass++;
        n_checks++;
        if ({start_compute, busy, done, in_ready} !== 4'b0000)
            $display("FAIL reset_ctrl got(sc,busy,done,rdy)=%b exp=0000", {start_compute, busy, done, in_ready});
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_basic();
        set_seq_beats(); set_vpat_all();
        build_model(N, 3);
        hz = e_done_cyc + 2;
        run_feed(0, 3, hz, -1);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL basic_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if (o_a[c] !== e_a[c]) $display("FAIL basic_a_edge cyc=%0d got=%h exp=%h", c, o_a[c], e_a[c]); else n_pass++;
                n_checks++;
                if (o_b[c] !== e_b[c]) $display("FAIL basic_b_edge cyc=%0d got=%h exp=%h", c, o_b[c], e_b[c]); else n_pass++;
            end
        end
        // 4th..6th enable cycles are cycles 5..7
        n_checks++;
        if ({o_a[5][31:24], o_a[6][31:24], o_a[7][31:24]} !== {8'd4, 8'd8, 8'd12})
            $display("FAIL basic_lane3 got=%h exp=04080c", {o_a[5][31:24], o_a[6][31:24], o_a[7][31:24]});
        else n_pass++;
    endtask

    task automatic test_stall();
        set_seq_beats(); set_vpat_all();
        vpat[2] = 1'b0; vpat[3] = 1'b0;
        build_model(N, 3);
        hz = e_done_cyc + 2;
        run_feed(0, 3, hz, -1);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL stall_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if ({o_a[c], o_b[c]} !== {e_a[c], e_b[c]})
                    $display("FAIL stall_edges cyc=%0d got=%h exp=%h", c, {o_a[c], o_b[c]}, {e_a[c], e_b[c]});
                else n_pass++;
            end
        end
        n_checks++;
        if (o_done[13] !== 1'b1) $display("FAIL stall_done13 got=%b exp=1", o_done[13]); else n_pass++;
`ifdef FEED_PERF_EN
        n_checks++;
        if (o_stall !== 16'(e_stall)) $display("FAIL stall_count got=%0d exp=%0d", o_stall, e_stall); else n_pass++;
`endif
    endtask

    task automatic test_zero_len();
        set_vpat_all();
        build_model(N, 0);
        hz = 5;
        run_feed(0, 0, hz, -1);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL zero_len_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
        end
`ifdef FEED_PERF_EN
        n_checks++;
        if (o_stall !== 16'd0) $display("FAIL zero_len_stall_count got=%0d exp=0", o_stall); else n_pass++;
`endif
    endtask

    task automatic test_restart_ignored();
        set_seq_beats(); set_vpat_all();
        build_model(N, 3);
        hz = e_done_cyc + 3;
        run_feed(0, 3, hz, 2);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL restart_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if (o_a[c] !== e_a[c]) $display("FAIL restart_a_edge cyc=%0d got=%h exp=%h", c, o_a[c], e_a[c]); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int K;
        for (int it = 0; it < 4; it++) begin
            K = $urandom_range(1, 6);
            for (int b = 0; b < 16; b++) begin
                beat_a[b] = (N*DW)'($urandom);
                beat_b[b] = (N*DW)'($urandom);
            end
            for (int c = 0; c < H; c++) vpat[c] = (c > 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            build_model(N, K);
            hz = e_done_cyc + 2;
            run_feed(0, K, hz, -1);
            for (int c = 0; c < hz; c++) begin
                n_checks++;
                if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                    $display("FAIL random_ctrl it=%0d cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", it, c,
                             {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
                else n_pass++;
                if (c > 0) begin
                    n_checks++;
                    if ({o_a[c], o_b[c]} !== {e_a[c], e_b[c]})
                        $display("FAIL random_edges it=%0d cyc=%0d got=%h exp=%h", it, c, {o_a[c], o_b[c]}, {e_a[c], e_b[c]});
                    else n_pass++;
                end
            end
`ifdef FEED_PERF_EN
            n_checks++;
            if (o_stall !== 16'(e_stall)) $display("FAIL random_stall_count it=%0d got=%0d exp=%0d", it, o_stall, e_stall); else n_pass++;
`endif
        end
    endtask

    task automatic test_async_reset();
        set_seq_beats(); set_vpat_all();
        build_model(N, 3);
        run_feed(0, 3, 7, -1);
        @(posedge clk); #2;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL async_pre_busy got=%b exp=1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_edge, b_edge} !== '0) $display("FAIL async_edges got=%h exp=0", {a_edge, b_edge}); else n_pass++;
        n_checks++;
        if ({start_compute, busy, done, in_ready} !== 4'b0000)
            $display("FAIL async_ctrl got(sc,busy,done,rdy)=%b exp=0000", {start_compute, busy, done, in_ready});
        else n_pass++;
        @(negedge clk); reset_n = 1'b1;
        hz = e_done_cyc + 2;
        run_feed(0, 3, hz, -1);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o_sc[c], o_done[c], o_busy[c], o_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL post_reset_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o_sc[c], o_done[c], o_busy[c], o_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if (o_a[c] !== e_a[c]) $display("FAIL post_reset_a_edge cyc=%0d got=%h exp=%h", c, o_a[c], e_a[c]); else n_pass++;
            end
        end
    endtask

    task automatic test_n1();
        for (int b = 0; b < 16; b++) begin
            beat_a[b] = '0;
            beat_b[b] = (N*DW)'($urandom);
        end
        beat_a[0][DW-1:0] = 8'd7;
        beat_a[1][DW-1:0] = 8'hFD;
        set_vpat_all();
        build_model(1, 2);
        hz = e_done_cyc + 2;
        run_feed(1, 2, hz, -1);
        for (int c = 0; c < hz; c++) begin
            n_checks++;
            if ({o1_sc[c], o1_done[c], o1_busy[c], o1_ready[c]} !== {e_sc[c], e_done[c], e_busy[c], e_ready[c]})
                $display("FAIL n1_ctrl cyc=%0d got(sc,done,busy,rdy)=%b exp=%b", c,
                         {o1_sc[c], o1_done[c], o1_busy[c], o1_ready[c]}, {e_sc[c], e_done[c], e_busy[c], e_ready[c]});
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if ({o1_a[c], o1_b[c]} !== {e_a[c][DW-1:0], e_b[c][DW-1:0]})
                    $display("FAIL n1_edges cyc=%0d got=%h exp=%h", c, {o1_a[c], o1_b[c]}, {e_a[c][DW-1:0], e_b[c][DW-1:0]});
                else n_pass++;
            end
        end
        n_checks++;
        if ({o1_a[2], o1_a[3], o1_done[4]} !== {8'd7, 8'hFD, 1'b1})
            $display("FAIL n1_fixed got=%h exp=%h", {o1_a[2], o1_a[3], o1_done[4]}, {8'd7, 8'hFD, 1'b1});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_restart_ignored();
        test_random();
        test_async_reset();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
